// File: rtl/fpu_cmd_issuer_pkg.sv
// Shared encodings for the FPU command issuer: operation codes, the NaN
// returned on abandoned requests, and the issue state machine states.
package fpu_cmd_issuer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO. A push into a full FIFO is dropped even when a
// pop happens in the same cycle; storage is not reset, only the pointers.
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Queues tagged FPU requests and runs them one at a time through the FPU
// start/busy/done handshake, returning result, flags and tag in order.
module fpu_cmd_issuer
    import fpu_cmd_issuer_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             fpu_start,
    output logic [1:0]       fpu_operation,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic [31:0]      fpu_z,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    input  logic             fpu_busy,
    input  logic             fpu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_z,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_ovf,
    output logic             rsp_unf,
    output logic             rsp_timeout,
    output logic             idle
);

    localparam int ENT_W = 2 + 32 + 32 + TAG_W;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;

    logic [1:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rsp_z;
    logic             r_rsp_ovf;
    logic             r_rsp_unf;
    logic             r_rsp_to;

    logic             w_at_limit;
    logic             w_cap_done;
    logic             w_cap_to;

    assign w_push  = cmd_valid && !w_full;
    assign w_wdata = {cmd_op, cmd_a, cmd_b, cmd_tag};

    fpu_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_at_limit = (r_cnt == CNT_MAX);

    // done is only looked at in WAIT, which is reachable only after busy was
    // seen, so a done level left over from the previous op cannot be captured.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cap_done  = 1'b0;
        w_cap_to    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !fpu_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_at_limit) begin
                    w_cap_to    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (fpu_busy) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_at_limit) begin
                    w_cap_to    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (fpu_done && !fpu_busy) begin
                    w_cap_done  = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_tag <= '0;
        end else if (w_pop) begin
            r_op  <= w_rdata[ENT_W-1 -: 2];
            r_a   <= w_rdata[ENT_W-3 -: 32];
            r_b   <= w_rdata[TAG_W+31 -: 32];
            r_tag <= w_rdata[TAG_W-1:0];
        end
    end

    // Saturating issue-to-completion counter, cleared on each pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (w_pop)
            r_cnt <= '0;
        else if ((r_state == ST_ISSUE || r_state == ST_WAIT) && !w_at_limit)
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_z   <= '0;
            r_rsp_ovf <= 1'b0;
            r_rsp_unf <= 1'b0;
            r_rsp_to  <= 1'b0;
        end else if (w_cap_to) begin
            r_rsp_z   <= FP_QNAN;
            r_rsp_ovf <= 1'b0;
            r_rsp_unf <= 1'b0;
            r_rsp_to  <= 1'b1;
        end else if (w_cap_done) begin
            r_rsp_z   <= fpu_z;
            r_rsp_ovf <= fpu_overflow;
            r_rsp_unf <= fpu_underflow;
            r_rsp_to  <= 1'b0;
        end
    end

    assign cmd_ready     = !w_full;
    assign fpu_start     = (r_state == ST_ISSUE);
    assign fpu_operation = r_op;
    assign fpu_a         = r_a;
    assign fpu_b         = r_b;
    assign rsp_valid     = (r_state == ST_RESP);
    assign rsp_z         = r_rsp_z;
    assign rsp_tag       = r_tag;
    assign rsp_ovf       = r_rsp_ovf;
    assign rsp_unf       = r_rsp_unf;
    assign rsp_timeout   = r_rsp_to;
    assign idle          = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Directed bench for fpu_cmd_issuer: behavioural FPU model with configurable
// busy delay/latency/hang, and an in-order scoreboard on the response port.
module tb_fpu_cmd_issuer;
    import fpu_cmd_issuer_pkg::*;

    localparam int TAG_W     = 4;
    localparam int CMD_DEPTH = 4;
    localparam int TO        = 60;

    typedef struct packed {
        logic [31:0]      z;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             unf;
        logic             to;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             fpu_start;
    logic [1:0]       fpu_operation;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [31:0]      fpu_z = '0;
    logic             fpu_overflow = 1'b0;
    logic             fpu_underflow = 1'b0;
    logic             fpu_busy = 1'b0;
    logic             fpu_done = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_z;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_ovf;
    logic             rsp_unf;
    logic             rsp_timeout;
    logic             idle;

    fpu_cmd_issuer #(
        .CMD_DEPTH   (CMD_DEPTH),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_tag       (cmd_tag),
        .fpu_start     (fpu_start),
        .fpu_operation (fpu_operation),
        .fpu_a         (fpu_a),
        .fpu_b         (fpu_b),
        .fpu_z         (fpu_z),
        .fpu_overflow  (fpu_overflow),
        .fpu_underflow (fpu_underflow),
        .fpu_busy      (fpu_busy),
        .fpu_done      (fpu_done),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_z         (rsp_z),
        .rsp_tag       (rsp_tag),
        .rsp_ovf       (rsp_ovf),
        .rsp_unf       (rsp_unf),
        .rsp_timeout   (rsp_timeout),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    rsp_t sb[$];

    // FPU model knobs
    int   m_delay = 0;
    int   m_lat   = 4;
    bit   m_hang  = 1'b0;
    bit   chk_ops = 1'b1;
    int   m_ph    = 0;
    int   m_c     = 0;
    logic [65:0] m_ops = '0;

    // Known results for the operand pairs used; anything else gets a
    // recognisable scramble so a wrong operand routing shows up.
    function automatic logic [33:0] fp_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [33:0] r;
        r = {2'b00, a ^ b ^ {30'd0, op}};
        case ({op, a, b})
            {OP_ADD, 32'h3F800000, 32'h40000000}: r = {2'b00, 32'h40400000};
            {OP_SUB, 32'h3F800000, 32'h40000000}: r = {2'b00, 32'hBF800000};
            {OP_MUL, 32'h40400000, 32'h40000000}: r = {2'b00, 32'h40C00000};
            {OP_DIV, 32'h40C00000, 32'h40000000}: r = {2'b00, 32'h40400000};
            {OP_ADD, 32'h3F800000, 32'h3F800000}: r = {2'b00, 32'h40000000};
            {OP_MUL, 32'h7F000000, 32'h7F000000}: r = {2'b10, 32'h7F800000};
            {OP_MUL, 32'h00800000, 32'h00800000}: r = {2'b01, 32'h00000000};
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        case (m_ph)
            0: if (fpu_start) begin
                m_ops <= {fpu_operation, fpu_a, fpu_b};
                if (m_delay == 0) begin
                    fpu_busy <= 1'b1; fpu_done <= 1'b0; m_c <= m_lat; m_ph <= 2;
                end else begin
                    m_c <= m_delay; m_ph <= 1;
                end
            end
            1: if (m_c <= 1) begin
                fpu_busy <= 1'b1; fpu_done <= 1'b0; m_c <= m_lat; m_ph <= 2;
            end else m_c <= m_c - 1;
            default: if (!m_hang) begin
                if (m_c <= 1) begin
                    fpu_busy <= 1'b0; fpu_done <= 1'b1;
                    {fpu_overflow, fpu_underflow, fpu_z} <= fp_calc(m_ops[65:64], m_ops[63:32], m_ops[31:0]);
                    m_ph <= 0;
                end else m_c <= m_c - 1;
            end
        endcase
    end

    // Response scoreboard and operand-stability monitor
    always @(negedge clk) begin
        rsp_t got;
        rsp_t exp;
        if (rst && rsp_valid && rsp_ready) begin
            got = '{z: rsp_z, tag: rsp_tag, ovf: rsp_ovf, unf: rsp_unf, to: rsp_timeout};
            n_total++;
            if (sb.size() == 0) begin
                n_bad++;
                $error("FAIL rsp_unexpected got=%h exp=none", got);
            end else begin
                exp = sb.pop_front();
                assert (got === exp) else begin
                    n_bad++;
                    $error("FAIL rsp tag=%0d got=%h exp=%h", exp.tag, got, exp);
                end
            end
        end
        if (rst && fpu_busy && chk_ops) begin
            n_total++;
            assert ({fpu_operation, fpu_a, fpu_b} === m_ops) else begin
                n_bad++;
                $error("FAIL ops_stable got=%h exp=%h", {fpu_operation, fpu_a, fpu_b}, m_ops);
            end
        end
    end

    // Start-to-response latency, in cycles
    logic prev_start = 1'b0;
    bit   lat_on     = 1'b0;
    int   lat_cnt    = 0;
    int   last_lat   = -1;
    always @(negedge clk) begin
        if (fpu_start && !prev_start) begin
            lat_cnt = 0; lat_on = 1'b1;
        end else if (lat_on) begin
            lat_cnt++;
            if (rsp_valid) begin last_lat = lat_cnt; lat_on = 1'b0; end
        end
        prev_start = fpu_start;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] ez,
                        input logic eo, input logic eu, input logic et);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        @(negedge clk);
        while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
        chk("push_accept", {63'd0, cmd_ready}, 64'd1);
        if (cmd_ready) sb.push_back('{z: ez, tag: tag, ovf: eo, unf: eu, to: et});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sb(input int lvl, input string name);
        int n = 0;
        while (sb.size() > lvl && n < 1000) begin @(negedge clk); n++; end
        chk(name, 64'(sb.size()), 64'(lvl));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {58'd0, fpu_start, rsp_valid, cmd_ready, idle, rsp_timeout, rsp_ovf}, 64'b001100);
        chk("rst_data", {fpu_a, rsp_z}, 64'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // single add, with issue latency
        push(OP_ADD, 32'h3F800000, 32'h40000000, 4'd1, 32'h40400000, 0, 0, 0);
        @(negedge clk); chk("start_n", {63'd0, fpu_start}, 64'd0);
        @(negedge clk); chk("start_n1", {63'd0, fpu_start}, 64'd1);
        @(posedge clk); #1;
        wait_sb(0, "drain_add");
        chk("idle_after", {63'd0, idle}, 64'd1);

        // back-to-back mixed ops
        push(OP_SUB, 32'h3F800000, 32'h40000000, 4'd2, 32'hBF800000, 0, 0, 0);
        push(OP_MUL, 32'h40400000, 32'h40000000, 4'd3, 32'h40C00000, 0, 0, 0);
        push(OP_DIV, 32'h40C00000, 32'h40000000, 4'd4, 32'h40400000, 0, 0, 0);
        push(OP_ADD, 32'h3F800000, 32'h3F800000, 4'd5, 32'h40000000, 0, 0, 0);
        wait_sb(0, "drain_b2b");

        // flag capture
        push(OP_MUL, 32'h7F000000, 32'h7F000000, 4'd6, 32'h7F800000, 1, 0, 0);
        push(OP_MUL, 32'h00800000, 32'h00800000, 4'd7, 32'h00000000, 0, 1, 0);
        wait_sb(0, "drain_flags");

        // backpressure: 1 held + CMD_DEPTH queued, then full
        rsp_ready = 1'b0;
        push(OP_ADD, 32'h3F800000, 32'h40000000, 4'd8,  32'h40400000, 0, 0, 0);
        push(OP_SUB, 32'h3F800000, 32'h40000000, 4'd9,  32'hBF800000, 0, 0, 0);
        push(OP_MUL, 32'h40400000, 32'h40000000, 4'd10, 32'h40C00000, 0, 0, 0);
        push(OP_DIV, 32'h40C00000, 32'h40000000, 4'd11, 32'h40400000, 0, 0, 0);
        push(OP_ADD, 32'h3F800000, 32'h3F800000, 4'd12, 32'h40000000, 0, 0, 0);
        @(negedge clk); chk("full_ready", {62'd0, cmd_ready, idle}, 64'd0);
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_a = 32'h7F000000; cmd_b = 32'h7F000000; cmd_tag = 4'd13;
        repeat (10) @(negedge clk);
        chk("still_full", {63'd0, cmd_ready}, 64'd0);
        chk("rsp_held", {63'd0, rsp_valid}, 64'd1);
        @(posedge clk); #1; rsp_ready = 1'b1;
        push(OP_MUL, 32'h7F000000, 32'h7F000000, 4'd13, 32'h7F800000, 1, 0, 0);
        wait_sb(0, "drain_bp");

        // timeout; next command blocked until busy drops
        m_hang = 1'b1;
        push(OP_ADD, 32'h3F800000, 32'h40000000, 4'd14, FP_QNAN, 0, 0, 1);
        push(OP_SUB, 32'h3F800000, 32'h40000000, 4'd15, 32'hBF800000, 0, 0, 0);
        wait_sb(1, "timeout_rsp");
        chk("timeout_lat", 64'(last_lat), 64'(TO + 1));
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (fpu_start) seen = 1'b1; end
        chk("blocked_by_busy", {63'd0, seen}, 64'd0);
        @(posedge clk); #1; m_hang = 1'b0;
        wait_sb(0, "drain_after_hang");

        // stale done with delayed busy
        chk("stale_done_lvl", {63'd0, fpu_done}, 64'd1);
        m_delay = 3;
        push(OP_ADD, 32'h3F800000, 32'h3F800000, 4'd0, 32'h40000000, 0, 0, 0);
        wait_sb(0, "drain_stale");
        m_delay = 0;

        // asynchronous reset while waiting on the FPU
        chk_ops = 1'b0; m_lat = 30;
        push(OP_MUL, 32'h40400000, 32'h40000000, 4'd1, 32'h40C00000, 0, 0, 0);
        push(OP_DIV, 32'h40C00000, 32'h40000000, 4'd2, 32'h40400000, 0, 0, 0);
        push(OP_SUB, 32'h3F800000, 32'h40000000, 4'd3, 32'hBF800000, 0, 0, 0);
        repeat (8) @(posedge clk);
        #3; rst = 1'b0;
        #1;
        chk("async_rst", {60'd0, fpu_start, rsp_valid, idle, cmd_ready}, 64'b0011);
        sb.delete();
        @(posedge clk); #1; rst = 1'b1;
        n = 0;
        while (fpu_busy && n < 200) begin @(negedge clk); n++; end
        chk("fpu_finish", {63'd0, fpu_busy}, 64'd0);
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (fpu_start || !idle) seen = 1'b1; end
        chk("fifo_flushed", {63'd0, seen}, 64'd0);
        @(posedge clk); #1;

        // normal operation after reset
        chk_ops = 1'b1; m_lat = 2;
        push(OP_ADD, 32'h3F800000, 32'h40000000, 4'd4, 32'h40400000, 0, 0, 0);
        wait_sb(0, "drain_final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_cmd_issuer.md
Name: fpu_cmd_issuer

Overview:
Initiator-side driver for the floating-point unit's start/busy/output_done handshake.
- Buffers tagged operation requests (op, a, b) in a small command FIFO.
- Issues each request to the FPU, one at a time, and waits for completion.
- Returns the result, overflow/underflow flags and tag on a valid/ready response port.
- Sits between a host or sequencer and the FPU top; it is the only FPU start source.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
TAG_W, 4, width of the request tag echoed on the response
TIMEOUT_CYC, 255, max cycles from issue to FPU completion before the request is abandoned

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  request present
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  2  00 add, 01 sub, 10 multiply, 11 divide
cmd_a  in  32  IEEE-754 single operand a
cmd_b  in  32  IEEE-754 single operand b
cmd_tag  in  TAG_W  request id
fpu_start  out  1  start request to FPU
fpu_operation  out  2  op held for the FPU
fpu_a  out  32  operand a held for the FPU
fpu_b  out  32  operand b held for the FPU
fpu_z  in  32  FPU result
fpu_overflow  in  1  FPU overflow flag
fpu_underflow  in  1  FPU underflow flag
fpu_busy  in  1  FPU busy
fpu_done  in  1  FPU output_done (level; stays high until next start)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_z  out  32  result
rsp_tag  out  TAG_W  echoed tag
rsp_ovf  out  1  captured overflow
rsp_unf  out  1  captured underflow
rsp_timeout  out  1  request abandoned on timeout
idle  out  1  FIFO empty and state IDLE

Behaviour:
- Reset (rst=0, any time, including mid-operation): FIFO emptied; state=IDLE; counter=0.
  - All outputs 0 except cmd_ready=1 and idle=1.
  - The FPU is not reset by this block.
- FIFO push: occurs on cmd_valid && cmd_ready. When full, cmd_ready=0 and no push happens, even if a pop occurs in the same cycle.
- Holding registers: the popped entry loads hold regs (op, a, b, tag). fpu_operation, fpu_a and fpu_b drive from the hold regs and stay stable from issue until the next pop.
- State machine: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty && !fpu_busy, pop, load hold regs, counter=0, go to ISSUE. A stale busy from a timed-out request therefore blocks issue.
  - ISSUE: fpu_start=1 (decoded from the state register).
    - fpu_busy=1 sampled: go to WAIT; fpu_start=0 from that cycle.
    - counter==TIMEOUT_CYC: go to RESP with timeout.
  - WAIT: fpu_start=0.
    - fpu_done=1 && fpu_busy=0: capture fpu_z and flags, go to RESP.
    - counter==TIMEOUT_CYC: go to RESP with timeout. Timeout has priority over done only if both occur in the same cycle at the limit.
    - The fpu_done level is ignored until busy has been seen, so stale done from the previous op is never captured.
  - RESP: rsp_valid=1; outputs stable until rsp_valid && rsp_ready, then go to IDLE.
  - The counter increments every cycle in ISSUE and WAIT and saturates at the limit.
- Timeout response: rsp_z=32'h7FC00000 (quiet NaN), rsp_timeout=1, rsp_ovf=rsp_unf=0, tag = held tag.
- Latency: a command pushed at edge N with an empty FIFO, an idle FPU and state IDLE gives fpu_start=1 after edge N+1.
  - Response latency = FPU latency + 2 cycles.
  - Back-to-back throughput is one op per FPU completion + 3 cycles when rsp_ready=1.
- Ordering: responses are returned strictly in command order; only one op is ever outstanding.
- idle: equals (FIFO empty && state==IDLE).

Decomposition:
- Shared package: op encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11), FP_QNAN=32'h7FC00000, state encodings.
- One natural sub-module: fpu_cmd_fifo.
  - Synchronous FIFO, width 2+32+32+TAG_W, depth CMD_DEPTH.
  - Ports: push/pop/full/empty; same async active-low reset.

Test Plan:
- Add: push op=00, a=32'h3F800000, b=32'h40000000, tag=1 against a real FPU → one fpu_start pulse window; rsp_z=32'h40400000, tag=1, ovf=unf=timeout=0.
- Four back-to-back pushes (sub 1.0−2.0, mul 3.0*2.0, div 6.0/2.0, add 1.0+1.0), tags 2..5, rsp_ready=1 → in-order results 32'hBF800000, 32'h40C00000, 32'h40400000, 32'h40000000; fpu_operands constant while busy.
- Backpressure: rsp_ready=0 and 6 pushes with CMD_DEPTH=4 → cmd_ready=0 after the 5th accept (4 in FIFO + 1 held); release rsp_ready → all 5 responses appear in order; the 6th push is accepted only once cmd_ready returns to 1.
- Timeout: FPU model holds busy=1 forever → after TIMEOUT_CYC cycles rsp_z=32'h7FC00000, rsp_timeout=1. The next queued command is not issued until the model drops busy.
- Stale done: FPU model leaves fpu_done=1 from the previous op and delays busy by 3 cycles → no capture until busy is seen and then drops.
- Reset mid-WAIT: drive rst=0 asynchronously → fpu_start=0, rsp_valid=0, idle=1 and cmd_ready=1 immediately; the FIFO is empty after release.
